// File: rtl/sipo_deframer.sv
// rtl/sipo_deframer.sv - serial-in/parallel-out word receiver with valid/ready holding register
// Assembles WIDTH-bit words MSB first from sin_en-qualified bits and flags framing/overrun errors.
module sipo_deframer #(
  parameter  int WIDTH = 4,
  parameter  int CONT  = 0,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  input  logic             clr,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  output logic             frame_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  // Only WIDTH-1 bits are ever held; the final bit is merged straight into the word.
  logic [WIDTH-2:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   pout_q, pout_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               ferr_q, ferr_d;
  logic               sync_q, sync_d;

  logic [WIDTH-1:0]   shifted;
  logic               drain;
  logic               take_first;
  logic               take_next;
  logic               complete;
  logic               set_ovr;
  logic               set_ferr;

  always_comb begin
    shifted    = {sreg_q, sin};
    drain      = valid_q & pout_ready;
    take_first = 1'b0;
    take_next  = 1'b0;
    set_ferr   = 1'b0;

    if (sin_en) begin
      if (sof) begin
        take_first = 1'b1;
        set_ferr   = (state_q == SHIFT);
      end else if (state_q == SHIFT) begin
        take_next  = 1'b1;
      end else if ((CONT != 0) && sync_q) begin
        take_first = 1'b1;
      end
    end

    complete = take_next && (cnt_q == LAST_IDX);
    set_ovr  = complete && valid_q && !drain;

    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    pout_d  = pout_q;
    valid_d = valid_q & ~drain;
    sync_d  = sync_q | (sin_en & sof);

    if (take_first) begin
      state_d   = SHIFT;
      sreg_d    = '0;
      sreg_d[0] = sin;
      cnt_d     = CW'(1);
    end else if (complete) begin
      state_d = IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
      // A full, undrained holding register keeps its word; the new one is lost.
      if (!set_ovr) begin
        pout_d  = shifted;
        valid_d = 1'b1;
      end
    end else if (take_next) begin
      sreg_d = shifted[WIDTH-2:0];
      cnt_d  = cnt_q + 1'b1;
    end

    ovr_d  = set_ovr  | (ovr_q  & ~clr);
    ferr_d = set_ferr | (ferr_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      pout_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      pout_q  <= pout_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      sync_q  <= sync_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = valid_q;
  assign busy       = (state_q == SHIFT);
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// tb/tb_sipo_deframer.sv - scoreboard bench for sipo_deframer, CONT=0 and CONT=1 side by side
// A bit-counting word model predicts words and flags; a negedge monitor compares DUT outputs.
module tb_sipo_deframer;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, sin = 1'b0, sin_en = 1'b0, sof = 1'b0, clr = 1'b0, pout_ready = 1'b0;

  logic [1:0][W-1:0]  pout;
  logic [1:0][CW-1:0] bit_cnt;
  logic [1:0]         pout_valid, busy, overrun, frame_err;

  sipo_deframer #(.WIDTH(W), .CONT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sof(sof), .clr(clr),
    .pout(pout[0]), .pout_valid(pout_valid[0]), .pout_ready(pout_ready),
    .busy(busy[0]), .bit_cnt(bit_cnt[0]), .overrun(overrun[0]), .frame_err(frame_err[0])
  );

  sipo_deframer #(.WIDTH(W), .CONT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sof(sof), .clr(clr),
    .pout(pout[1]), .pout_valid(pout_valid[1]), .pout_ready(pout_ready),
    .busy(busy[1]), .bit_cnt(bit_cnt[1]), .overrun(overrun[1]), .frame_err(frame_err[1])
  );

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_words [2];
  bit           mon_en = 1'b0;

  // Reference model: bits-so-far count and accumulated value per DUT.
  int           m_cnt  [2];
  int           m_acc  [2];
  bit           m_full [2];
  bit           m_ovr  [2];
  bit           m_ferr [2];
  bit           m_sync [2];
  logic [W-1:0] exp_q0 [$];
  logic [W-1:0] exp_q1 [$];

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [W-1:0] qfront(input int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic qpush(input int d, input logic [W-1:0] w);
    if (d == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  task automatic qpop(input int d);
    if (d == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic qflush(input int d);
    if (d == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  task automatic model_step(input int d);
    bit           done;
    bit           s_ovr;
    bit           s_fe;
    logic [W-1:0] word;
    if (!rst_n) begin
      m_cnt[d] = 0; m_acc[d] = 0; m_full[d] = 0;
      m_ovr[d] = 0; m_ferr[d] = 0; m_sync[d] = 0;
      qflush(d);
      return;
    end
    done = 0; s_ovr = 0; s_fe = 0; word = '0;
    if (m_full[d] && pout_ready) m_full[d] = 0;
    if (sin_en) begin
      if (sof) begin
        s_fe      = (m_cnt[d] != 0);
        m_acc[d]  = int'(sin);
        m_cnt[d]  = 1;
        m_sync[d] = 1;
      end else if (m_cnt[d] != 0 || (d == 1 && m_sync[d])) begin
        m_acc[d] = m_acc[d] * 2 + int'(sin);
        m_cnt[d] = m_cnt[d] + 1;
        if (m_cnt[d] == W) begin
          done     = 1;
          word     = m_acc[d][W-1:0];
          m_cnt[d] = 0;
          m_acc[d] = 0;
        end
      end
    end
    if (done) begin
      if (m_full[d]) s_ovr = 1;
      else begin
        qpush(d, word);
        m_full[d] = 1;
      end
    end
    m_ovr[d]  = s_ovr || (m_ovr[d]  && !clr);
    m_ferr[d] = s_fe  || (m_ferr[d] && !clr);
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  task automatic monitor(input int d);
    check("pout_valid", d, 32'(pout_valid[d]), 32'(m_full[d]));
    check("busy",       d, 32'(busy[d]),       32'(m_cnt[d] != 0));
    check("bit_cnt",    d, 32'(bit_cnt[d]),    32'(m_cnt[d]));
    check("overrun",    d, 32'(overrun[d]),    32'(m_ovr[d]));
    check("frame_err",  d, 32'(frame_err[d]),  32'(m_ferr[d]));
    if (pout_valid[d] === 1'b1) begin
      check("exp_pending", d, 32'(qsize(d)), 32'd1);
      if (qsize(d) != 0) begin
        check("pout", d, 32'(pout[d]), 32'(qfront(d)));
        if (pout_ready) begin
          qpop(d);
          n_words[d]++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) for (int d = 0; d < 2; d++) monitor(d);
  end

  task automatic drive(input logic rn, input logic en, input logic s, input logic f,
                       input logic c, input logic r);
    @(posedge clk);
    #1;
    rst_n = rn; sin_en = en; sin = s; sof = f; clr = c; pout_ready = r;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic send(input logic [W-1:0] w, input bit with_sof, input int gap, input logic r);
    for (int i = W - 1; i >= 0; i--) begin
      drive(1'b1, 1'b1, w[i], 1'(with_sof && i == W - 1), 1'b0, r);
      repeat (gap) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r);
    end
  endtask

  initial begin
    n_words[0] = 0;
    n_words[1] = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("reset_pout", d, 32'(pout[d]), 32'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'b1011, 1, 0, 1'b1);
    idle(3, 1'b1);
    send(4'b0110, 1, 3, 1'b1);
    idle(3, 1'b1);

    send(4'hA, 1, 0, 1'b0);
    send(4'h5, 1, 0, 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send(4'b0111, 0, 0, 1'b1);
    idle(3, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    send(4'h9, 1, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'hC, 1, 0, 1'b1);
    send(4'h3, 0, 0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_mid_pout",    d, 32'(pout[d]),    32'd0);
      check("rst_mid_bit_cnt", d, 32'(bit_cnt[d]), 32'd0);
    end

    for (int k = 0; k < 4000; k++) begin
      logic rn, en, f, c, r, s;
      rn = 1'($urandom_range(0, 299) != 0);
      en = 1'($urandom_range(0, 9) < 6);
      f  = en && ($urandom_range(0, 11) == 0);
      c  = 1'($urandom_range(0, 39) == 0);
      s  = 1'($urandom_range(0, 1));
      r  = (((k / 50) % 2) == 0) ? 1'($urandom_range(0, 9) < 8) : 1'($urandom_range(0, 9) < 2);
      drive(rn, en, s, f, c, r);
    end
    idle(4, 1'b1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("words_seen_min", d, 32'(n_words[d] >= 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
